// File: rtl/alu_share_arbiter_if.sv
// Bundle between the issue logic, the shared-ALU arbiter and the ALU instance.
// master = issue logic plus ALU; slave = arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_c;
    logic             alu_zero;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output rsp_ready, alu_c, alu_zero,
        input  req_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_data, rsp_zero, rsp_err, busy, op_count
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input  rsp_ready, alu_c, alu_zero,
        output req_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_data, rsp_zero, rsp_err, busy, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, one op in flight.
// Accept -> response valid two cycles later; response held until the granted requester takes it.
module alu_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_PASSB = 3'b100;

    state_t           state;
    logic             gnt_id;
    logic             last_gnt;
    logic             err;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;
    logic             err_q;
    logic [1:0]       rsp_vld_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic             win;
    logic             take;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic             illegal;

    // A lone request always wins; a tie goes to whoever was not served last.
    always_comb begin
        win     = (bus.req_valid == 2'b11) ? ~last_gnt : bus.req_valid[1];
        take    = rst_n && (state == IDLE) && (bus.req_valid != 2'b00);
        sel_a   = win ? bus.req1_a  : bus.req0_a;
        sel_b   = win ? bus.req1_b  : bus.req0_b;
        sel_op  = win ? bus.req1_op : bus.req0_op;
        illegal = (sel_op > OP_PASSB);
    end

    assign bus.req_ready = take ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = busy_q;
    assign bus.op_count  = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_id    <= 1'b0;
            last_gnt  <= 1'b1;
            err       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= 3'b000;
            data_q    <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
            rsp_vld_q <= 2'b00;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        // Illegal ops still take a slot; the ALU just sees a harmless PASSB.
                        ctrl_q <= illegal ? OP_PASSB : sel_op;
                        err    <= illegal;
                        gnt_id <= win;
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (err) begin
                        data_q <= '0;
                        zero_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        data_q <= bus.alu_c;
                        zero_q <= bus.alu_zero;
                        err_q  <= 1'b0;
                    end
                    rsp_vld_q <= gnt_id ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[gnt_id]) begin
                        rsp_vld_q <= 2'b00;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        last_gnt <= gnt_id;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_share_arbiter;
    localparam int W = 32;
    localparam int C = 2;

    typedef struct {
        logic [1:0]   vld;
        logic [W-1:0] data;
        logic         zero;
        logic         err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   last_wait;
    int   n;
    exp_t q[$];

    alu_share_arbiter_if #(.WIDTH(W), .CNT_W(C)) bus ();

    alu_share_arbiter #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [W-1:0] alu_model(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return b;
        endcase
    endfunction

    assign bus.alu_c    = alu_model(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = (bus.alu_c == '0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op);
        exp_t e;
        e.vld = id ? 2'b10 : 2'b01;
        e.err = (op > 3'b100);
        case (op)
            3'b000:  e.data = a + b;
            3'b001:  e.data = a - b;
            3'b010:  e.data = a & b;
            3'b011:  e.data = a | b;
            3'b100:  e.data = b;
            default: e.data = '0;
        endcase
        e.zero = e.err ? 1'b1 : (e.data == '0);
        q.push_back(e);
    endtask

    task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic get_rsp(input string tag);
        exp_t e;
        int k;
        k = 0;
        while (bus.rsp_valid == 2'b00 && k < 20) begin
            step();
            k++;
        end
        last_wait = k;
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, "_vld"},  32'(bus.rsp_valid), 32'(e.vld));
            chk({tag, "_data"}, 32'(bus.rsp_data),  32'(e.data));
            chk({tag, "_zero"}, 32'(bus.rsp_zero),  32'(e.zero));
            chk({tag, "_err"},  32'(bus.rsp_err),   32'(e.err));
        end
    endtask

    initial begin
        errors = 0; checks = 0; last_wait = 0;
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
        set_req(1'b0, '0, '0, 3'b000);
        set_req(1'b1, '0, '0, 3'b000);
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        bus.req_valid = 2'b11;
        step(); step(); #1;
        chk("rst_busy",  32'(bus.busy),      32'h0);
        chk("rst_rvld",  32'(bus.rsp_valid), 32'h0);
        chk("rst_cnt",   32'(bus.op_count),  32'h0);
        chk("rst_rdy",   32'(bus.req_ready), 32'h0);
        chk("rst_ctrl",  32'(bus.alu_ctrl),  32'h0);
        chk("rst_data",  32'(bus.rsp_data),  32'h0);
        step();
        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        step();

        // Requester 0 ADD 5+3
        set_req(1'b0, 32'd5, 32'd3, 3'b000);
        bus.req_valid = 2'b01; bus.rsp_ready = 2'b11;
        #1 chk("add_rdy", 32'(bus.req_ready), 32'h1);
        push(1'b0, 32'd5, 32'd3, 3'b000);
        step();
        bus.req_valid = 2'b00;
        #1;
        chk("add_busy",  32'(bus.busy),      32'h1);
        chk("add_rdy0",  32'(bus.req_ready), 32'h0);
        chk("add_rvld0", 32'(bus.rsp_valid), 32'h0);
        chk("add_alua",  32'(bus.alu_a),     32'd5);
        chk("add_alub",  32'(bus.alu_b),     32'd3);
        get_rsp("add");
        chk("add_lat", 32'(last_wait), 32'd1);
        step();
        chk("add_cnt",  32'(bus.op_count),  32'd1);
        chk("add_idle", 32'(bus.busy),      32'h0);
        chk("add_done", 32'(bus.rsp_valid), 32'h0);

        // Requester 1 SUB 5-5
        set_req(1'b1, 32'd5, 32'd5, 3'b001);
        bus.req_valid = 2'b10;
        #1 chk("sub_rdy", 32'(bus.req_ready), 32'h2);
        push(1'b1, 32'd5, 32'd5, 3'b001);
        step();
        bus.req_valid = 2'b00;
        get_rsp("sub");
        step();
        chk("sub_cnt", 32'(bus.op_count), 32'd2);

        // Both requesting continuously: grants alternate starting with 0
        set_req(1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 3'b010);
        set_req(1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 3'b011);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) push(i[0], 32'hF0F0F0F0, 32'h0F0F0F0F, i[0] ? 3'b011 : 3'b010);
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (bus.req_ready == 2'b00 && n < 20) begin
                step(); #1; n++;
            end
            chk("alt_gnt", 32'(bus.req_ready), i[0] ? 32'h2 : 32'h1);
            get_rsp("alt");
            if (i == 3) bus.req_valid = 2'b00;
            step();
        end
        chk("sat_cnt", 32'(bus.op_count), 32'd3);

        // Backpressure on PASSB, with requester 1 waiting and its rsp_ready ignored
        bus.rsp_ready = 2'b00;
        set_req(1'b0, 32'h1234, 32'h55555555, 3'b100);
        bus.req_valid = 2'b01;
        #1 chk("bp_rdy", 32'(bus.req_ready), 32'h1);
        push(1'b0, 32'h1234, 32'h55555555, 3'b100);
        step();
        bus.req_valid = 2'b00;
        step();
        set_req(1'b1, 32'd1, 32'd2, 3'b000);
        bus.req_valid = 2'b10; bus.rsp_ready = 2'b10;
        push(1'b1, 32'd1, 32'd2, 3'b000);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rvld", 32'(bus.rsp_valid), 32'h1);
            chk("bp_data", 32'(bus.rsp_data),  32'h55555555);
            chk("bp_rdy0", 32'(bus.req_ready), 32'h0);
            chk("bp_busy", 32'(bus.busy),      32'h1);
            step();
        end
        bus.rsp_ready = 2'b01;
        get_rsp("bp");
        step();
        #1 chk("held_rdy", 32'(bus.req_ready), 32'h2);
        bus.rsp_ready = 2'b11;
        step();
        bus.req_valid = 2'b00;
        get_rsp("held");
        step();

        // Illegal op from requester 1, then a legal op clears the error
        set_req(1'b1, 32'd9, 32'd9, 3'b111);
        bus.req_valid = 2'b10;
        #1 chk("ill_rdy", 32'(bus.req_ready), 32'h2);
        push(1'b1, 32'd9, 32'd9, 3'b111);
        step();
        bus.req_valid = 2'b00;
        #1 chk("ill_ctrl", 32'(bus.alu_ctrl), 32'h4);
        get_rsp("ill");
        step();
        chk("ill_hold", 32'(bus.rsp_err), 32'h1);
        set_req(1'b0, 32'd1, 32'd2, 3'b011);
        bus.req_valid = 2'b01;
        push(1'b0, 32'd1, 32'd2, 3'b011);
        step();
        bus.req_valid = 2'b00;
        get_rsp("clr");
        step();
        chk("sat_cnt2", 32'(bus.op_count), 32'd3);

        // Reset while a response is pending
        bus.rsp_ready = 2'b00;
        set_req(1'b0, 32'd1, 32'd1, 3'b000);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        step();
        #1 chk("mid_rvld", 32'(bus.rsp_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rvld", 32'(bus.rsp_valid), 32'h0);
        chk("arst_busy", 32'(bus.busy),      32'h0);
        chk("arst_cnt",  32'(bus.op_count),  32'h0);
        step(); step();
        rst_n = 1'b1;
        set_req(1'b0, 32'd10, 32'd4, 3'b001);
        set_req(1'b1, 32'd7,  32'd7, 3'b010);
        bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
        #1 chk("post_gnt", 32'(bus.req_ready), 32'h1);
        push(1'b0, 32'd10, 32'd4, 3'b001);
        step();
        bus.req_valid = 2'b00;
        get_rsp("post");
        step();
        chk("post_cnt", 32'(bus.op_count), 32'd1);
        chk("sb_empty", 32'(q.size()),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
